// File: rtl/alarm_bank_snooze.sv
// alarm_bank_snooze: a bank of NUM_ALARMS alarm slots (time plus day mask)
// that share one ring FSM (IDLE/RINGING/SNOOZED). The FSM handles snooze
// countdown, the snooze limit and the ring timeout.
// Everything advances on the 1/sec Pulse, the same pulse that drives the
// time counters.
module alarm_bank_snooze #(
    parameter int          NUM_ALARMS   = 4,
    parameter int          SNOOZE_MIN   = 9,
    parameter int          MAX_SNOOZE   = 3,
    parameter int          RING_SEC     = 60,
    parameter logic [6:0]  DEFAULT_MASK = 7'b0111110,
    localparam int         IW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  Pulse,
    input  logic                  Reset,
    input  logic [6:0]            TSec,
    input  logic [6:0]            TMin,
    input  logic [6:0]            THrs,
    input  logic [2:0]            Day,
    input  logic                  Alarmon,
    input  logic [NUM_ALARMS-1:0] AlmEn,
    input  logic                  Alarmset,
    input  logic [IW-1:0]         Sel,
    input  logic                  Minadv,
    input  logic                  Hrsadv,
    input  logic                  MaskWr,
    input  logic [6:0]            MaskIn,
    input  logic                  Stop,
    input  logic                  Snooze,
    output logic                  Buzz,
    output logic                  Snoozed,
    output logic [IW-1:0]         ActIdx,
    output logic [9:0]            SnzLeft,
    output logic [6:0]            DMin,
    output logic [6:0]            DHrs,
    output logic [6:0]            DMask,
    output logic [1:0]            DbgState
);

    localparam int RW  = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [9:0]     SNZ_LOAD = 10'(SNOOZE_MIN * 60 - 1);
    localparam logic [RW-1:0]  RING_END = RW'(RING_SEC - 1);
    localparam logic [SCW-1:0] SNZ_MAX  = SCW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZED = 2'd2
    } state_t;

    // Slot storage
    logic [6:0] r_amin [NUM_ALARMS];
    logic [6:0] r_ahrs [NUM_ALARMS];
    logic [6:0] r_mask [NUM_ALARMS];

    // Edge-detect history
    logic r_match_prev;
    logic r_stop_prev;
    logic r_snz_prev;

    // Ring FSM state and counters
    state_t         r_state;
    logic [RW-1:0]  r_ring_cnt;
    logic [SCW-1:0] r_snz_cnt;
    logic [9:0]     r_snz_left;
    logic [IW-1:0]  r_act_idx;

    state_t         w_state_nx;
    logic [RW-1:0]  w_ring_nx;
    logic [SCW-1:0] w_scnt_nx;
    logic [9:0]     w_snzl_nx;
    logic [IW-1:0]  w_act_nx;

    logic [NUM_ALARMS-1:0] w_slot_match;
    logic [IW-1:0]         w_winner;
    logic                  w_match_now;
    logic                  w_trigger;
    logic                  w_stop_ev;
    logic                  w_snz_ev;

    // Slot setting: minute/hour advance wrap without carry.
    // A Sel value that names no slot matches no index, so the write is dropped.
    always_ff @(posedge Pulse or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_amin[i] <= 7'd0;
                r_ahrs[i] <= 7'd0;
                r_mask[i] <= DEFAULT_MASK;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (Sel == IW'(i)) begin
                    if (Alarmset && Minadv)
                        r_amin[i] <= (r_amin[i] == 7'd59) ? 7'd0 : r_amin[i] + 7'd1;
                    if (Alarmset && Hrsadv)
                        r_ahrs[i] <= (r_ahrs[i] == 7'd23) ? 7'd0 : r_ahrs[i] + 7'd1;
                    if (MaskWr)
                        r_mask[i] <= MaskIn;
                end
            end
        end
    end

    // Display readback of the selected slot; an out-of-range Sel reads zero
    always_comb begin
        DMin  = 7'd0;
        DHrs  = 7'd0;
        DMask = 7'd0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (Sel == IW'(i)) begin
                DMin  = r_amin[i];
                DHrs  = r_ahrs[i];
                DMask = r_mask[i];
            end
        end
    end

    // Per-slot compare against the running time. Day 7 is not a valid day.
    always_comb begin
        w_slot_match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_slot_match[i] = AlmEn[i] && (TMin == r_amin[i]) && (THrs == r_ahrs[i])
                              && (Day != 3'd7) && r_mask[i][Day];
        end
    end

    // Lowest matching index wins
    always_comb begin
        w_winner = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_slot_match[i])
                w_winner = IW'(i);
        end
    end

    assign w_match_now = Alarmon && !Alarmset && (TSec == 7'd0) && (|w_slot_match);
    assign w_trigger   = w_match_now && !r_match_prev;
    assign w_stop_ev   = Stop && !r_stop_prev;
    assign w_snz_ev    = Snooze && !r_snz_prev;

    // Edge history. A frozen clock that keeps matching cannot retrigger.
    always_ff @(posedge Pulse or posedge Reset) begin
        if (Reset) begin
            r_match_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_snz_prev   <= 1'b0;
        end else begin
            r_match_prev <= w_match_now;
            r_stop_prev  <= Stop;
            r_snz_prev   <= Snooze;
        end
    end

    // Ring FSM next-state. Priority is Alarmon low, then stop, then snooze,
    // then timeout/countdown. Any move to IDLE clears the snooze bookkeeping.
    always_comb begin
        w_state_nx = r_state;
        w_ring_nx  = r_ring_cnt;
        w_scnt_nx  = r_snz_cnt;
        w_snzl_nx  = r_snz_left;
        w_act_nx   = r_act_idx;
        if (!Alarmon) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        w_state_nx = S_RINGING;
                        w_act_nx   = w_winner;
                        w_ring_nx  = '0;
                        w_scnt_nx  = '0;
                    end
                end
                S_RINGING: begin
                    if (w_stop_ev) begin
                        w_state_nx = S_IDLE;
                    end else if (w_snz_ev) begin
                        if (r_snz_cnt < SNZ_MAX) begin
                            w_state_nx = S_SNOOZED;
                            w_snzl_nx  = SNZ_LOAD;
                            w_scnt_nx  = r_snz_cnt + 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else if (r_ring_cnt == RING_END) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ring_nx = r_ring_cnt + 1'b1;
                    end
                end
                S_SNOOZED: begin
                    if (w_stop_ev) begin
                        w_state_nx = S_IDLE;
                    end else if (r_snz_left == 10'd0) begin
                        w_state_nx = S_RINGING;
                        w_ring_nx  = '0;
                    end else begin
                        w_snzl_nx = r_snz_left - 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        if (w_state_nx == S_IDLE) begin
            w_snzl_nx = 10'd0;
            w_scnt_nx = '0;
            w_ring_nx = '0;
        end
    end

    // Ring FSM state register
    always_ff @(posedge Pulse or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_snz_left <= 10'd0;
            r_act_idx  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ring_cnt <= w_ring_nx;
            r_snz_cnt  <= w_scnt_nx;
            r_snz_left <= w_snzl_nx;
            r_act_idx  <= w_act_nx;
        end
    end

    assign Buzz     = (r_state == S_RINGING);
    assign Snoozed  = (r_state == S_SNOOZED);
    assign ActIdx   = r_act_idx;
    assign SnzLeft  = r_snz_left;
    assign DbgState = r_state;

endmodule

// File: tb/tb_alarm_bank_snooze.sv
// Bench for alarm_bank_snooze with default parameters (4 slots).
// Each step pushes the expected {Buzz, Snoozed, ActIdx, SnzLeft} word,
// advances one Pulse, then pops that word and compares it with the DUT.
module tb_alarm_bank_snooze;

    logic       Pulse;
    logic       Reset;
    logic [6:0] TSec, TMin, THrs;
    logic [2:0] Day;
    logic       Alarmon;
    logic [3:0] AlmEn;
    logic       Alarmset;
    logic [1:0] Sel;
    logic       Minadv, Hrsadv, MaskWr;
    logic [6:0] MaskIn;
    logic       Stop, Snooze;
    logic       Buzz, Snoozed;
    logic [1:0] ActIdx;
    logic [9:0] SnzLeft;
    logic [6:0] DMin, DHrs, DMask;
    logic [1:0] DbgState;

    int n_checks = 0;
    int n_fail   = 0;
    logic [13:0] exp_q[$];

    alarm_bank_snooze dut (
        .Pulse(Pulse), .Reset(Reset), .TSec(TSec), .TMin(TMin), .THrs(THrs),
        .Day(Day), .Alarmon(Alarmon), .AlmEn(AlmEn), .Alarmset(Alarmset),
        .Sel(Sel), .Minadv(Minadv), .Hrsadv(Hrsadv), .MaskWr(MaskWr),
        .MaskIn(MaskIn), .Stop(Stop), .Snooze(Snooze), .Buzz(Buzz),
        .Snoozed(Snoozed), .ActIdx(ActIdx), .SnzLeft(SnzLeft), .DMin(DMin),
        .DHrs(DHrs), .DMask(DMask), .DbgState(DbgState)
    );

    // Clock
    initial Pulse = 1'b0;
    always #5 Pulse = ~Pulse;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [13:0] mk(input logic b, input logic s,
                                       input logic [1:0] a, input logic [9:0] l);
        return {b, s, a, l};
    endfunction

    task automatic tick();
        @(posedge Pulse);
        #1;
    endtask

    // Push expected word, run one Pulse, pop and compare
    task automatic tick_exp(input string tag, input logic [13:0] e);
        exp_q.push_back(e);
        tick();
        chk(tag, {18'd0, Buzz, Snoozed, ActIdx, SnzLeft}, {18'd0, exp_q.pop_front()});
    endtask

    task automatic set_time(input int h, input int m, input int s);
        THrs = 7'(h);
        TMin = 7'(m);
        TSec = 7'(s);
    endtask

    task automatic set_slot(input int sel, input int hrs, input int mins);
        Alarmset = 1'b1;
        Sel      = 2'(sel);
        Hrsadv   = 1'b1;
        repeat (hrs) tick();
        Hrsadv   = 1'b0;
        Minadv   = 1'b1;
        repeat (mins) tick();
        Minadv   = 1'b0;
        Alarmset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Alarmon = 1'b0; AlmEn = 4'b0000; Alarmset = 1'b0;
        Sel = 2'd0; Minadv = 1'b0; Hrsadv = 1'b0; MaskWr = 1'b0; MaskIn = 7'd0;
        Stop = 1'b0; Snooze = 1'b0; Day = 3'd2;
        set_time(0, 0, 1);
        repeat (2) tick();

        // Reset state
        chk("rst_buzz", 32'(Buzz), 0);
        chk("rst_snoozed", 32'(Snoozed), 0);
        chk("rst_actidx", 32'(ActIdx), 0);
        chk("rst_snzleft", 32'(SnzLeft), 0);
        chk("rst_dmin", 32'(DMin), 0);
        chk("rst_dhrs", 32'(DHrs), 0);
        chk("rst_dmask", 32'(DMask), 32'h3E);
        Reset = 1'b0;
        tick();

        // Slot 0 = 06:30
        set_slot(0, 6, 30);
        chk("set0_dmin", 32'(DMin), 30);
        chk("set0_dhrs", 32'(DHrs), 6);

        // Basic ring and 60-second timeout
        Alarmon = 1'b1; AlmEn = 4'b0001; Day = 3'd2;
        set_time(6, 29, 59);
        tick_exp("pre_ring", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("ring_start", mk(1, 0, 0, 0));
        for (int k = 1; k < 60; k++) begin
            set_time(6, 30, k);
            tick_exp("ring_hold", mk(1, 0, 0, 0));
        end
        set_time(6, 31, 0);
        tick_exp("ring_timeout", mk(0, 0, 0, 0));

        // Day masked off, then mask rewritten to all days
        Day = 3'd0;
        set_time(6, 29, 59);
        tick_exp("day0_pre", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("day0_masked", mk(0, 0, 0, 0));
        set_time(6, 30, 1);
        MaskWr = 1'b1; MaskIn = 7'h7F;
        tick_exp("maskwr", mk(0, 0, 0, 0));
        MaskWr = 1'b0;
        chk("dmask_7f", 32'(DMask), 32'h7F);
        set_time(6, 29, 59);
        tick_exp("day0_pre2", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("day0_ring", mk(1, 0, 0, 0));
        Stop = 1'b1;
        tick_exp("day0_stop", mk(0, 0, 0, 0));
        Stop = 1'b0;
        tick_exp("day0_idle", mk(0, 0, 0, 0));

        // Slots 1 and 3 at 07:00, lowest index wins, frozen time triggers once
        Day = 3'd2;
        set_slot(1, 7, 0);
        set_slot(3, 7, 60);
        chk("set3_min_wrap", 32'(DMin), 0);
        chk("set3_dhrs", 32'(DHrs), 7);
        AlmEn = 4'b1010;
        set_time(6, 59, 59);
        tick_exp("two_pre", mk(0, 0, 0, 0));
        set_time(7, 0, 0);
        tick_exp("two_ring", mk(1, 0, 1, 0));
        Stop = 1'b1;
        tick_exp("two_stop", mk(0, 0, 1, 0));
        Stop = 1'b0;
        for (int k = 0; k < 5; k++) tick_exp("frozen_no_retrig", mk(0, 0, 1, 0));
        AlmEn = 4'b1000;
        set_time(6, 59, 59);
        tick_exp("slot3_pre", mk(0, 0, 1, 0));
        set_time(7, 0, 0);
        tick_exp("slot3_ring", mk(1, 0, 3, 0));
        Stop = 1'b1;
        tick_exp("slot3_stop", mk(0, 0, 3, 0));
        Stop = 1'b0;

        // Snooze cycles with limit; time frozen at 06:30:00 after the trigger
        AlmEn = 4'b1011;
        set_time(6, 29, 59);
        tick_exp("snz_pre", mk(0, 0, 3, 0));
        set_time(6, 30, 0);
        tick_exp("snz_ring", mk(1, 0, 0, 0));
        for (int r = 0; r < 3; r++) begin
            Snooze = 1'b1;
            tick_exp("snz_enter", mk(0, 1, 0, 539));
            Snooze = 1'b0;
            for (int k = 1; k < 540; k++) begin
                if (r == 0 && k == 100) Snooze = 1'b1;
                tick_exp("snz_count", mk(0, 1, 0, 10'(539 - k)));
                Snooze = 1'b0;
            end
            tick_exp("snz_rering", mk(1, 0, 0, 0));
        end
        Snooze = 1'b1;
        tick_exp("snz_limit", mk(0, 0, 0, 0));
        Snooze = 1'b0;
        tick_exp("snz_limit_idle", mk(0, 0, 0, 0));

        // Stop and Snooze together
        set_time(6, 29, 59);
        tick_exp("both_pre", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("both_ring", mk(1, 0, 0, 0));
        Stop = 1'b1; Snooze = 1'b1;
        tick_exp("both_stop", mk(0, 0, 0, 0));
        Stop = 1'b0; Snooze = 1'b0;
        tick_exp("both_idle", mk(0, 0, 0, 0));

        // Alarmon dropped while snoozed
        set_time(6, 29, 59);
        tick_exp("aoff_pre", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("aoff_ring", mk(1, 0, 0, 0));
        Snooze = 1'b1;
        tick_exp("aoff_snz", mk(0, 1, 0, 539));
        Snooze = 1'b0;
        tick_exp("aoff_cnt1", mk(0, 1, 0, 538));
        tick_exp("aoff_cnt2", mk(0, 1, 0, 537));
        Alarmon = 1'b0;
        tick_exp("aoff_idle", mk(0, 0, 0, 0));
        Alarmon = 1'b1;
        set_time(6, 30, 1);
        tick_exp("aoff_back", mk(0, 0, 0, 0));

        // Hour wrap on slot 2
        Alarmset = 1'b1; Sel = 2'd2; Hrsadv = 1'b1;
        repeat (25) tick();
        Hrsadv = 1'b0; Alarmset = 1'b0;
        chk("hrs_wrap", 32'(DHrs), 1);
        chk("hrs_wrap_min", 32'(DMin), 0);

        // Async reset mid-ring
        set_time(6, 29, 59);
        tick_exp("rst_pre", mk(0, 0, 0, 0));
        set_time(6, 30, 0);
        tick_exp("rst_ring", mk(1, 0, 0, 0));
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_async_buzz", 32'(Buzz), 0);
        chk("rst_async_state", 32'(DbgState), 0);
        chk("rst_slot2_hrs", 32'(DHrs), 0);
        Sel = 2'd0;
        #1;
        chk("rst_slot0_min", 32'(DMin), 0);
        chk("rst_slot0_mask", 32'(DMask), 32'h3E);
        tick();
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_bank_snooze.md
Name: alarm_bank_snooze

Overview:
- Multi-alarm engine for the alarm clock; replaces the single-alarm compare and weekday gating at top level.
- Holds NUM_ALARMS independent alarm settings (minute, hour, 7-bit day mask, enable) and compares them against the running time from the clock counters.
- A shared ring FSM (IDLE/RINGING/SNOOZED) drives Buzz, with snooze countdown, snooze limit and ring timeout.
- Clocked by the same 1/sec Pulse as the time counters.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..8).
- SNOOZE_MIN, 9, snooze length in minutes.
- MAX_SNOOZE, 3, snoozes allowed per trigger; a further Snooze acts as Stop.
- RING_SEC, 60, seconds of unattended ringing before auto-stop.
- DEFAULT_MASK, 7'b0111110, day mask loaded at reset (bit d = ring on day d; days 1-5).

Ports:
- Pulse  in  1  clock, 1/sec; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- TSec, TMin, THrs  in  7 each  current time (0-59, 0-59, 0-23).
- Day  in  3  current day 0-6.
- Alarmon  in  1  global alarm enable.
- AlmEn  in  NUM_ALARMS  per-slot enable.
- Alarmset  in  1  setting mode for slot Sel.
- Sel  in  IW  slot being set/displayed; IW = max(1,$clog2(NUM_ALARMS)).
- Minadv, Hrsadv  in  1 each  advance selected slot minute/hour while Alarmset.
- MaskWr  in  1  load MaskIn into selected slot mask.
- MaskIn  in  7  new day mask.
- Stop, Snooze  in  1 each  user buttons, level; rising edge acts.
- Buzz  out  1  alarm sounding.
- Snoozed  out  1  FSM in SNOOZED.
- ActIdx  out  IW  slot that caused current ring/snooze.
- SnzLeft  out  10  seconds remaining in snooze.
- DMin, DHrs  out  7 each  selected slot setting, for display mux.
- DMask  out  7  selected slot mask.

Behaviour:
- Reset (async): all slots 0:00 with mask DEFAULT_MASK; FSM IDLE. Buzz=0, Snoozed=0, ActIdx=0, SnzLeft=0, snooze count 0, button history 0.
- Setting: while Alarmset=1, each Pulse with Minadv=1 advances slot[Sel] minute mod 60 (59->0, no carry into hours); Hrsadv advances hour mod 24 (23->0). Both high advances both.
  - MaskWr=1 loads MaskIn into mask[Sel] regardless of Alarmset.
  - Sel out of range (>= NUM_ALARMS): writes ignored, DMin/DHrs/DMask read 0.
  - DMin/DHrs/DMask are combinational from Sel.
- Match: slot i matches when AlmEn[i], TMin==AMin[i], THrs==AHrs[i] and mask[i][Day]=1.
  - match_now = Alarmon & ~Alarmset & (TSec==0) & any slot match.
  - match_prev is registered; trigger = match_now & ~match_prev, so a frozen clock cannot retrigger.
  - Winning slot is the lowest matching index.
- Button events: stop_ev and snz_ev are rising edges against registered previous button values. Holding a button produces one event.
- FSM, evaluated each Pulse:
  - IDLE: on trigger -> RINGING; ActIdx = winner, ring counter = 0, snooze count = 0.
  - RINGING: Buzz=1; ring counter +1 per Pulse.
    - stop_ev -> IDLE.
    - snz_ev with snooze count < MAX_SNOOZE -> SNOOZED; SnzLeft = SNOOZE_MIN*60-1; snooze count +1.
    - snz_ev with snooze count == MAX_SNOOZE -> IDLE.
    - ring counter reaching RING_SEC-1 with no event -> IDLE.
  - SNOOZED: Snoozed=1, Buzz=0; SnzLeft decrements each Pulse.
    - At SnzLeft==0 -> RINGING with ring counter cleared.
    - stop_ev -> IDLE. snz_ev ignored.
- Priority within one Pulse: Alarmon=0 (forces IDLE from any state) > stop_ev > snz_ev > timeout/countdown.
- Triggers arriving in RINGING or SNOOZED are dropped; they do not change ActIdx.
- Leaving to IDLE clears SnzLeft and snooze count.
- Buzz is registered and reflects the state after the edge; latency from trigger condition to Buzz=1 is one Pulse.
- Changing a slot setting mid-ring does not affect the active ring.

Test Plan:
- Reset, slot0 = 06:30, AlmEn=0001, Alarmon=1, Day=2, time 06:29:59 -> 06:30:00 -> Buzz=1 one Pulse later, ActIdx=0; stays 1 for 60 Pulses, then 0.
- Same setup with Day=0 (mask bit 0 clear) -> Buzz stays 0; MaskWr with MaskIn=7'h7F, repeat -> Buzz=1.
- Slots 1 and 3 both 07:00, both enabled -> ActIdx=1. Hold TSec=0 and TMin=0 for 5 Pulses (Timeset) -> only one trigger.
- Ringing, Snooze pulse -> Buzz=0, Snoozed=1, SnzLeft=539; after 540 Pulses Buzz=1. Fourth Snooze (MAX_SNOOZE=3) -> IDLE.
- Ringing, Stop and Snooze rise on the same Pulse -> IDLE. Alarmon dropped during SNOOZED -> IDLE, SnzLeft=0.
- Alarmset=1, Sel=2, Hrsadv held 25 Pulses from 0 -> DHrs=1. Reset asserted mid-RINGING -> Buzz=0 immediately, slot 2 returns to 0:00.
